// File: rtl/mpc_constraint_fill_sched_if.sv
// Handshake, configuration, external-request and h-RAM port bundle for the
// constraint-vector fill scheduler.
interface mpc_constraint_fill_sched_if #(
  parameter int NSEG   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int SEL_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;

  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_len;
  logic [DATA_W-1:0] cfg_val;

  logic              ext_req;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic              ext_gnt;

  logic [ADDR_W-1:0] h_address0;
  logic              h_ce0;
  logic              h_we0;
  logic [DATA_W-1:0] h_d0;

  // Sequencer / requester side
  modport master (
    output ap_start,
    input  ap_done, ap_idle, ap_ready,
    output cfg_we, cfg_sel, cfg_base, cfg_len, cfg_val,
    output ext_req, ext_addr, ext_data,
    input  ext_gnt,
    input  h_address0, h_ce0, h_we0, h_d0
  );

  // Fill engine side
  modport slave (
    input  ap_start,
    output ap_done, ap_idle, ap_ready,
    input  cfg_we, cfg_sel, cfg_base, cfg_len, cfg_val,
    input  ext_req, ext_addr, ext_data,
    output ext_gnt,
    output h_address0, h_ce0, h_we0, h_d0
  );
endinterface

// File: rtl/mpc_constraint_fill_sched.sv
// Runtime-configurable fill engine for the dense-MPC constraint vector h:
// writes NSEG constant-valued segments and shares the h port with an external writer.
module mpc_constraint_fill_sched #(
  parameter int NSEG   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  mpc_constraint_fill_sched_if.slave bus
);
  localparam int SEL_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SEL_W-1:0] LAST_SEG = SEL_W'(NSEG - 1);
  localparam logic signed [DATA_W-1:0] VAL_POS = DATA_W'(32'sh000A0000);
  localparam logic signed [DATA_W-1:0] VAL_NEG = DATA_W'(32'shFFF60000);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          s_q, s_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;

  logic [ADDR_W-1:0]         base_q [NSEG];
  logic [ADDR_W-1:0]         len_q  [NSEG];
  logic signed [DATA_W-1:0]  val_q  [NSEG];

  logic [ADDR_W-1:0]         cur_base;
  logic [ADDR_W-1:0]         cur_len;
  logic signed [DATA_W-1:0]  cur_val;
  logic [ADDR_W-1:0]         fill_addr;
  logic                      seg_end;
  logic                      fill_wr;
  logic                      ext_gnt;
  logic                      cfg_ok;

  assign cur_base  = base_q[s_q];
  assign cur_len   = len_q[s_q];
  assign cur_val   = val_q[s_q];
  // Modulo-2^ADDR_W address: the sum simply drops its carry.
  assign fill_addr = cur_base + idx_q;

  // A zero-length segment still consumes one (skip) cycle.
  assign seg_end = (cur_len == '0) || (idx_q == cur_len - ADDR_W'(1));
  assign fill_wr = (state_q == ST_FILL) && (cur_len != '0);

  // Fill has absolute priority; a start request in IDLE already blocks the grant.
  assign ext_gnt = ap_rst_n && bus.ext_req && (state_q == ST_IDLE) && !bus.ap_start;

  assign cfg_ok = bus.cfg_we && (state_q == ST_IDLE) && (32'(bus.cfg_sel) < NSEG);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ap_start) begin
          state_d = ST_FILL;
          s_d     = '0;
          idx_d   = '0;
        end
      end
      ST_FILL: begin
        if (seg_end) begin
          idx_d = '0;
          if (s_q == LAST_SEG) begin
            state_d = ST_DONE;
          end else begin
            s_d = s_q + SEL_W'(1);
          end
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Segment configuration; reset restores the fixed-constant layout h[16..31].
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        base_q[k] <= ADDR_W'(16 + 4 * k);
        len_q[k]  <= ADDR_W'(4);
        val_q[k]  <= ((k % 2) == 0) ? VAL_POS : VAL_NEG;
      end
    end else if (cfg_ok) begin
      base_q[bus.cfg_sel] <= bus.cfg_base;
      len_q[bus.cfg_sel]  <= bus.cfg_len;
      val_q[bus.cfg_sel]  <= $signed(bus.cfg_val);
    end
  end

  always_comb begin
    bus.h_ce0      = 1'b0;
    bus.h_we0      = 1'b0;
    bus.h_address0 = '0;
    bus.h_d0       = '0;
    if (fill_wr) begin
      bus.h_ce0      = 1'b1;
      bus.h_we0      = 1'b1;
      bus.h_address0 = fill_addr;
      bus.h_d0       = cur_val;
    end else if (ext_gnt) begin
      bus.h_ce0      = 1'b1;
      bus.h_we0      = 1'b1;
      bus.h_address0 = bus.ext_addr;
      bus.h_d0       = bus.ext_data;
    end
  end

  assign bus.ext_gnt  = ext_gnt;
  assign bus.ap_done  = (state_q == ST_DONE);
  assign bus.ap_ready = (state_q == ST_DONE);
  assign bus.ap_idle  = (state_q == ST_IDLE) && !bus.ap_start;

endmodule

// File: tb/tb_mpc_constraint_fill_sched.sv
// Directed bench for mpc_constraint_fill_sched: default fill, skip/wrap,
// arbitration, ignored inputs and reset in the middle of a fill.
module tb_mpc_constraint_fill_sched;
  logic ap_clk;
  logic ap_rst_n;

  int n_tot = 0;
  int n_bad = 0;

  bit          e_we [$];
  logic [4:0]  e_ad [$];
  logic [31:0] e_dt [$];

  mpc_constraint_fill_sched_if #(.NSEG(4), .ADDR_W(5), .DATA_W(32)) bus ();

  mpc_constraint_fill_sched #(.NSEG(4), .ADDR_W(5), .DATA_W(32)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic exp_clear();
    e_we.delete();
    e_ad.delete();
    e_dt.delete();
  endtask

  task automatic exp_push(input bit we, input logic [4:0] a, input logic [31:0] d);
    e_we.push_back(we);
    e_ad.push_back(a);
    e_dt.push_back(d);
  endtask

  task automatic exp_default();
    for (int i = 0; i < 16; i++)
      exp_push(1'b1, 5'(16 + i), (((i / 4) % 2) == 1) ? 32'hFFF60000 : 32'h000A0000);
  endtask

  task automatic cfg_write(input int sel, input logic [4:0] b, input logic [4:0] l,
                           input logic [31:0] v);
    next_cyc();
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 2'(sel);
    bus.cfg_base = b;
    bus.cfg_len  = l;
    bus.cfg_val  = v;
    next_cyc();
    bus.cfg_we   = 1'b0;
  endtask

  // Start pulse in cycle 0, expected write list in cycles 1..W, DONE in W+1, IDLE in W+2.
  task automatic run_fill(input int abort_at, input bit poke);
    int n;
    n = e_we.size();
    next_cyc();
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    check_val("start_idle", bus.ap_idle, 0);
    check_val("start_gnt", bus.ext_gnt, 0);
    check_val("start_we", bus.h_we0, 0);
    for (int c = 1; c <= n; c++) begin
      next_cyc();
      if (c == 1) bus.ap_start = 1'b0;
      if (poke && c == 3) begin
        bus.ap_start = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'd0;
        bus.cfg_base = 5'd5;
        bus.cfg_len  = 5'd1;
        bus.cfg_val  = 32'h99;
      end
      if (poke && c == 4) begin
        bus.ap_start = 1'b0;
        bus.cfg_we   = 1'b0;
      end
      @(negedge ap_clk);
      check_val("fill_we", bus.h_we0, e_we[c-1]);
      check_val("fill_ce", bus.h_ce0, e_we[c-1]);
      if (e_we[c-1]) begin
        check_val("fill_addr", bus.h_address0, e_ad[c-1]);
        check_val("fill_data", bus.h_d0, e_dt[c-1]);
      end
      check_val("fill_done", bus.ap_done, 0);
      check_val("fill_gnt", bus.ext_gnt, 0);
      check_val("fill_idle", bus.ap_idle, 0);
      if (c == abort_at) begin
        #1 ap_rst_n = 1'b0;
        #1;
        check_val("rst_we", bus.h_we0, 0);
        check_val("rst_ce", bus.h_ce0, 0);
        check_val("rst_idle", bus.ap_idle, 1);
        check_val("rst_done", bus.ap_done, 0);
        check_val("rst_gnt", bus.ext_gnt, 0);
        return;
      end
    end
    next_cyc();
    @(negedge ap_clk);
    check_val("done_pulse", bus.ap_done, 1);
    check_val("ready_pulse", bus.ap_ready, 1);
    check_val("done_we", bus.h_we0, 0);
    check_val("done_idle", bus.ap_idle, 0);
    check_val("done_gnt", bus.ext_gnt, 0);
    next_cyc();
    @(negedge ap_clk);
    check_val("post_done", bus.ap_done, 0);
    check_val("post_idle", bus.ap_idle, 1);
    check_val("post_gnt", bus.ext_gnt, bus.ext_req);
    if (bus.ext_req) check_val("post_addr", bus.h_address0, 32'd3);
  endtask

  initial begin
    ap_rst_n     = 1'b0;
    bus.ap_start = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = '0;
    bus.cfg_base = '0;
    bus.cfg_len  = '0;
    bus.cfg_val  = '0;
    bus.ext_req  = 1'b1;
    bus.ext_addr = 5'd7;
    bus.ext_data = 32'h55;

    #12;
    check_val("rst_idle0", bus.ap_idle, 1);
    check_val("rst_done0", bus.ap_done, 0);
    check_val("rst_ready0", bus.ap_ready, 0);
    check_val("rst_we0", bus.h_we0, 0);
    check_val("rst_ce0", bus.h_ce0, 0);
    check_val("rst_gnt0", bus.ext_gnt, 0);
    check_val("rst_addr0", bus.h_address0, 0);
    check_val("rst_d0", bus.h_d0, 0);
    bus.ext_req = 1'b0;
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    // Default layout: 16 writes to h[16..31], done in cycle 17
    exp_clear();
    exp_default();
    run_fill(0, 1'b0);

    // Skip and wrap
    cfg_write(0, 5'd30, 5'd4, 32'd5);
    cfg_write(1, 5'd20, 5'd0, 32'd0);
    cfg_write(2, 5'd0,  5'd1, 32'd7);
    cfg_write(3, 5'd28, 5'd0, 32'd0);
    exp_clear();
    exp_push(1'b1, 5'd30, 32'd5);
    exp_push(1'b1, 5'd31, 32'd5);
    exp_push(1'b1, 5'd0,  32'd5);
    exp_push(1'b1, 5'd1,  32'd5);
    exp_push(1'b0, 5'd0,  32'd0);
    exp_push(1'b1, 5'd0,  32'd7);
    exp_push(1'b0, 5'd0,  32'd0);
    run_fill(0, 1'b0);

    // Arbitration: external request held across the whole fill
    next_cyc();
    bus.ext_req  = 1'b1;
    bus.ext_addr = 5'd3;
    bus.ext_data = 32'h1234;
    @(negedge ap_clk);
    check_val("pre_gnt", bus.ext_gnt, 1);
    check_val("pre_we", bus.h_we0, 1);
    check_val("pre_addr", bus.h_address0, 32'd3);
    check_val("pre_data", bus.h_d0, 32'h1234);
    run_fill(0, 1'b0);
    next_cyc();
    bus.ext_req = 1'b0;

    // cfg_we and ap_start pulsed during FILL are dropped
    run_fill(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      @(negedge ap_clk);
      check_val("no_restart_we", bus.h_we0, 0);
      check_val("no_restart_idle", bus.ap_idle, 1);
    end
    run_fill(0, 1'b0);

    // Reset on the fifth write, then a clean restart uses the defaults
    cfg_write(1, 5'd10, 5'd3, 32'h11);
    exp_clear();
    exp_push(1'b1, 5'd30, 32'd5);
    exp_push(1'b1, 5'd31, 32'd5);
    exp_push(1'b1, 5'd0,  32'd5);
    exp_push(1'b1, 5'd1,  32'd5);
    exp_push(1'b1, 5'd10, 32'h11);
    exp_push(1'b1, 5'd11, 32'h11);
    exp_push(1'b1, 5'd12, 32'h11);
    exp_push(1'b1, 5'd0,  32'd7);
    exp_push(1'b0, 5'd0,  32'd0);
    run_fill(5, 1'b0);
    next_cyc();
    next_cyc();
    check_val("rst_hold_idle", bus.ap_idle, 1);
    ap_rst_n = 1'b1;
    exp_clear();
    exp_default();
    run_fill(0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/mpc_constraint_fill_sched.md
# mpc_constraint_fill_sched

Controller that sequences the initialisation of the dense-MPC constraint vector `h`. It replaces per-segment fixed-constant fill pipelines with one runtime-configurable engine. The engine writes up to `NSEG` segments, each holding a constant bound value, into `h` at one word per cycle. It also shares the single `h` write port with an external requester, such as the state-dependent constraint update. It sits between the top-level `mpc_dense_constraint` sequencer and the `h` RAM, and uses the standard `ap_ctrl_hs` start/done handshake.

## Interface
Parameters:
- `NSEG`, 4, number of constraint segments
- `ADDR_W`, 5, `h` address width (32 entries)
- `DATA_W`, 32, word width (Q16.16 fixed point)

Ports:
- `ap_clk`  in  1  sole clock, rising edge
- `ap_rst_n`  in  1  asynchronous, active-low reset
- `ap_start`  in  1  start request, sampled in IDLE only
- `ap_done`  out  1  one-cycle pulse when the fill completes
- `ap_idle`  out  1  high in IDLE when `ap_start`=0
- `ap_ready`  out  1  one-cycle pulse, coincident with `ap_done`
- `cfg_we`  in  1  configuration write strobe
- `cfg_sel`  in  clog2(NSEG)  segment index being configured
- `cfg_base`  in  ADDR_W  segment start address
- `cfg_len`  in  ADDR_W  segment length in words (0 = skip)
- `cfg_val`  in  DATA_W  constant written to every word of the segment
- `ext_req`  in  1  external write request
- `ext_addr`  in  ADDR_W  external write address
- `ext_data`  in  DATA_W  external write data
- `ext_gnt`  out  1  external write accepted this cycle
- `h_address0`  out  ADDR_W  RAM address
- `h_ce0`  out  1  RAM enable
- `h_we0`  out  1  RAM write enable
- `h_d0`  out  DATA_W  RAM write data

## Operation
- Configuration registers per segment k: `base`, `len`, `val`.
  - Reset defaults: `base` = 16+4k (mod 2^ADDR_W), `len` = 4.
  - Reset default `val` = 32'h000A0000 (+10.0) for even k and 32'hFFF60000 (−10.0) for odd k.
- `cfg_we` takes effect only in IDLE. It is ignored in FILL and DONE.
- FSM states: IDLE, FILL, DONE.
  - IDLE → FILL when `ap_start`=1. Segment counter `s` and index `idx` are cleared to 0.
  - FILL, `len[s]`≠0: drive `h_ce0`=`h_we0`=1, `h_address0`=`base[s]`+`idx`, `h_d0`=`val[s]`.
    - If `idx`=`len[s]`−1, set `idx`=0 and `s`=`s`+1; otherwise `idx`=`idx`+1.
  - FILL, `len[s]`=0: one skip cycle with no write, then `s`=`s`+1.
  - FILL → DONE after segment `NSEG`−1 completes.
  - DONE → IDLE unconditionally. `ap_done` and `ap_ready` are 1 only in DONE.
- Address arithmetic is `ADDR_W`-bit modulo: base+idx wraps past 2^ADDR_W−1 to 0.
- Overlapping segments are legal. A later segment overwrites an earlier one.
- Arbitration on the shared `h` port:
  - `ext_gnt` = `ext_req` AND state=IDLE AND `ap_start`=0. The fill has absolute priority.
  - When granted, `h_address0`/`h_d0` follow `ext_addr`/`ext_data` and `h_ce0`=`h_we0`=1.
  - If `ext_req` and `ap_start` arrive together in IDLE, start wins and `ext_gnt`=0.
- `ap_start` asserted in FILL or DONE is ignored; it is not queued.
- When there is no grant and no fill write, `h_ce0`=`h_we0`=0. `h_address0` and `h_d0` then hold don't-care values; the bench must not check them.

## Timing
- Reset (asynchronous, on `ap_rst_n`=0): state=IDLE, configuration returns to defaults, `s`=`idx`=0.
  - Reset output values: `ap_done`=`ap_ready`=0, `ap_idle`=1, `h_ce0`=`h_we0`=0, `ext_gnt`=0, `h_address0`=0, `h_d0`=0.
- Reset mid-FILL: `h_we0` falls immediately, with no clock edge needed. The partial fill is abandoned and a new `ap_start` is required.
- Write and grant timing:
  - All `h_*` write-enable and grant outputs are combinational from the registered state and the ext inputs.
  - A RAM write commits on the edge that ends the cycle.
- Latency: `ap_start` seen in IDLE at cycle 0. FILL occupies cycles 1..W, where W = Σ max(`len[k]`,1). `ap_done` is high in cycle W+1. IDLE resumes at W+2.
- Default configuration gives W=16. The fill writes `h`[16..31], and `ap_done` is high in cycle 17.
- `ap_idle` is 0 from the cycle after start through DONE.

## Test plan
- **Defaults:** release reset, pulse `ap_start`.
  - 16 writes occur, at addresses 16..31 in order.
  - Data is 0x000A0000 at 16–19 and 24–27, and 0xFFF60000 at 20–23 and 28–31.
  - `ap_done` pulses in cycle 17.
- **Skip and wrap:** cfg seg0 base=30 len=4 val=5, seg1 len=0, seg2 len=1 base=0 val=7, seg3 len=0.
  - Write addresses are 30, 31, 0, 1, then a skip cycle, then 0 (data 7), then a skip cycle.
  - W=7, so `ap_done` is high in cycle 8.
- **Arbitration:** hold `ext_req` with addr=3 data=0x1234 across start.
  - `ext_gnt`=1 in IDLE before start.
  - `ext_gnt`=0 in the start cycle and throughout FILL and DONE.
  - `ext_gnt` returns to 1 in the first IDLE cycle after DONE.
- **Ignored inputs:** during FILL, pulse `cfg_we` and `ap_start`. Configuration is unchanged and no second fill starts after DONE.
- **Reset mid-fill:** assert `ap_rst_n`=0 at write 5.
  - `h_we0` drops with no clock edge and `ap_idle` is 1.
  - A restart produces the default 16-write sequence even if the configuration was changed before reset.
